// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single memory port: load/store (D) has priority over fetch (I),
// with a bounded D streak so a pending fetch cannot starve. One access in flight, registered outputs.
module mem_port_arbiter #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int D_STREAK_MAX   = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        I_REQ,
   input  logic [31:0] I_ADDR,
   output logic [31:0] I_RDATA,
   output logic        I_DONE,
   output logic        I_ERR,
   input  logic        D_REQ,
   input  logic        D_WE,
   input  logic [31:0] D_ADDR,
   input  logic [31:0] D_WDATA,
   input  logic [3:0]  D_WSTRB,
   output logic [31:0] D_RDATA,
   output logic        D_DONE,
   output logic        D_ERR,
   output logic        M_REQ,
   output logic        M_WE,
   output logic [31:0] M_ADDR,
   output logic [31:0] M_WDATA,
   output logic [3:0]  M_WSTRB,
   input  logic [31:0] M_RDATA,
   input  logic        M_ACK
);

   localparam int TM_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int SK_W = (D_STREAK_MAX > 0) ? $clog2(D_STREAK_MAX + 1) : 1;
   localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT_CYCLES - 1);
   localparam logic [SK_W-1:0] SK_MAX  = SK_W'(D_STREAK_MAX);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

   state_t            state_q, state_d;
   logic [SK_W-1:0]   streak_q, streak_d;
   logic [TM_W-1:0]   timer_q, timer_d;
   logic              owner_q, owner_d;
   logic              m_req_q, m_req_d;
   logic              m_we_q, m_we_d;
   logic [31:0]       m_addr_q, m_addr_d;
   logic [31:0]       m_wdata_q, m_wdata_d;
   logic [3:0]        m_wstrb_q, m_wstrb_d;
   logic [31:0]       i_rdata_q, i_rdata_d;
   logic              i_done_q, i_done_d;
   logic              i_err_q, i_err_d;
   logic [31:0]       d_rdata_q, d_rdata_d;
   logic              d_done_q, d_done_d;
   logic              d_err_q, d_err_d;
   logic              d_wins;

   // I is forced only when it is actually waiting and D has used up its streak
   assign d_wins = D_REQ && !(I_REQ && (D_STREAK_MAX != 0) && (streak_q == SK_MAX));

   always_comb begin
      state_d   = state_q;
      streak_d  = streak_q;
      timer_d   = timer_q;
      owner_d   = owner_q;
      m_req_d   = m_req_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_wstrb_d = m_wstrb_q;
      i_rdata_d = 32'h0;
      i_done_d  = 1'b0;
      i_err_d   = 1'b0;
      d_rdata_d = 32'h0;
      d_done_d  = 1'b0;
      d_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (I_REQ || D_REQ) begin
               state_d = ST_BUSY;
               m_req_d = 1'b1;
               timer_d = '0;
               owner_d = d_wins;
               if (d_wins) begin
                  m_we_d    = D_WE;
                  m_addr_d  = D_ADDR;
                  m_wdata_d = D_WDATA;
                  m_wstrb_d = D_WE ? D_WSTRB : 4'h0;
                  if (!I_REQ)
                     streak_d = '0;
                  else if (streak_q != SK_MAX)
                     streak_d = streak_q + SK_W'(1);
               end else begin
                  m_we_d    = 1'b0;
                  m_addr_d  = I_ADDR;
                  m_wdata_d = 32'h0;
                  m_wstrb_d = 4'h0;
                  streak_d  = '0;
               end
            end
         end
         ST_BUSY: begin
            timer_d = timer_q + TM_W'(1);
            if (M_ACK) begin
               m_req_d = 1'b0;
               state_d = ST_RESP;
               if (owner_q) begin
                  d_done_d  = 1'b1;
                  d_rdata_d = M_RDATA;
               end else begin
                  i_done_d  = 1'b1;
                  i_rdata_d = M_RDATA;
               end
            end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TM_LAST)) begin
               m_req_d = 1'b0;
               state_d = ST_RESP;
               if (owner_q) begin
                  d_done_d = 1'b1;
                  d_err_d  = 1'b1;
               end else begin
                  i_done_d = 1'b1;
                  i_err_d  = 1'b1;
               end
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         streak_q  <= '0;
         timer_q   <= '0;
         owner_q   <= 1'b0;
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= 32'h0;
         m_wdata_q <= 32'h0;
         m_wstrb_q <= 4'h0;
         i_rdata_q <= 32'h0;
         i_done_q  <= 1'b0;
         i_err_q   <= 1'b0;
         d_rdata_q <= 32'h0;
         d_done_q  <= 1'b0;
         d_err_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         streak_q  <= streak_d;
         timer_q   <= timer_d;
         owner_q   <= owner_d;
         m_req_q   <= m_req_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_wstrb_q <= m_wstrb_d;
         i_rdata_q <= i_rdata_d;
         i_done_q  <= i_done_d;
         i_err_q   <= i_err_d;
         d_rdata_q <= d_rdata_d;
         d_done_q  <= d_done_d;
         d_err_q   <= d_err_d;
      end
   end

   assign M_REQ   = m_req_q;
   assign M_WE    = m_we_q;
   assign M_ADDR  = m_addr_q;
   assign M_WDATA = m_wdata_q;
   assign M_WSTRB = m_wstrb_q;
   assign I_RDATA = i_rdata_q;
   assign I_DONE  = i_done_q;
   assign I_ERR   = i_err_q;
   assign D_RDATA = d_rdata_q;
   assign D_DONE  = d_done_q;
   assign D_ERR   = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expected grants/completions,
// a negedge monitor pops and compares them. A second instance runs with strict D priority.
module tb_mem_port_arbiter;

   logic        clk, rst;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_wstrb;
   logic        m_ack;
   logic [31:0] mem_rdata;

   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic        i_done, i_err, d_done, d_err, m_req, m_we;
   logic [3:0]  m_wstrb;

   logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata;
   logic        b_i_done, b_i_err, b_d_done, b_d_err, b_m_req, b_m_we;
   logic [3:0]  b_m_wstrb;

   mem_port_arbiter #(.TIMEOUT_CYCLES(8), .D_STREAK_MAX(4)) dut_a (
      .CLK(clk), .RST(rst),
      .I_REQ(i_req), .I_ADDR(i_addr), .I_RDATA(i_rdata), .I_DONE(i_done), .I_ERR(i_err),
      .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata), .D_WSTRB(d_wstrb),
      .D_RDATA(d_rdata), .D_DONE(d_done), .D_ERR(d_err),
      .M_REQ(m_req), .M_WE(m_we), .M_ADDR(m_addr), .M_WDATA(m_wdata), .M_WSTRB(m_wstrb),
      .M_RDATA(mem_rdata), .M_ACK(m_ack)
   );

   mem_port_arbiter #(.TIMEOUT_CYCLES(0), .D_STREAK_MAX(0)) dut_b (
      .CLK(clk), .RST(rst),
      .I_REQ(i_req), .I_ADDR(i_addr), .I_RDATA(b_i_rdata), .I_DONE(b_i_done), .I_ERR(b_i_err),
      .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata), .D_WSTRB(d_wstrb),
      .D_RDATA(b_d_rdata), .D_DONE(b_d_done), .D_ERR(b_d_err),
      .M_REQ(b_m_req), .M_WE(b_m_we), .M_ADDR(b_m_addr), .M_WDATA(b_m_wdata), .M_WSTRB(b_m_wstrb),
      .M_RDATA(32'h0BAD_F00D), .M_ACK(b_m_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          len;
   } grant_t;

   typedef struct {
      logic        is_d;
      logic        err;
      logic [31:0] rdata;
   } done_t;

   grant_t exp_grant[$];
   done_t  exp_done[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_grant(input logic is_d, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb, input int len);
      grant_t g;
      g.is_d = is_d; g.we = we; g.addr = addr; g.wdata = wdata; g.wstrb = wstrb; g.len = len;
      exp_grant.push_back(g);
   endtask

   task automatic push_done(input logic is_d, input logic err, input logic [31:0] rdata);
      done_t e;
      e.is_d = is_d; e.err = err; e.rdata = rdata;
      exp_done.push_back(e);
   endtask

   // memory responder: acks ack_delay cycles into the request, or never when ack_en=0
   logic ack_en, ack_force;
   int   ack_delay;
   int   busy_cnt = 0;
   always @(negedge clk) begin
      if (m_req) begin
         m_ack    = ack_force || (ack_en && (busy_cnt == ack_delay));
         busy_cnt = busy_cnt + 1;
      end else begin
         busy_cnt = 0;
         m_ack    = ack_force;
      end
   end

   // scoreboard monitor for dut_a
   logic   m_req_prev = 1'b0;
   logic   fell;
   int     len_cnt = 0;
   int     len_exp = 0;
   grant_t g_cur;
   done_t  d_cur;
   always @(negedge clk) begin
      fell = m_req_prev && !m_req;
      if (m_req && !m_req_prev) begin
         if (exp_grant.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL grant_unexpected: got addr %h expected no grant", m_addr);
         end else begin
            g_cur = exp_grant.pop_front();
            check("grant_addr", m_addr, g_cur.addr);
            check("grant_we", 32'(m_we), 32'(g_cur.we));
            check("grant_wstrb", 32'(m_wstrb), 32'(g_cur.wstrb));
            if (g_cur.we) check("grant_wdata", m_wdata, g_cur.wdata);
            len_exp = g_cur.len;
         end
         len_cnt = 1;
      end else if (m_req) begin
         len_cnt = len_cnt + 1;
      end else if (fell && len_exp != 0) begin
         check("req_len", len_cnt, len_exp);
      end
      if (i_done || d_done) begin
         if (exp_done.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL done_unexpected: got i_done=%0b d_done=%0b expected none", i_done, d_done);
         end else begin
            d_cur = exp_done.pop_front();
            check("done_owner_d", 32'(d_done), 32'(d_cur.is_d));
            check("done_owner_i", 32'(i_done), 32'(!d_cur.is_d));
            check("done_err", 32'(d_cur.is_d ? d_err : i_err), 32'(d_cur.err));
            check("done_other_err", 32'(d_cur.is_d ? i_err : d_err), 32'h0);
            check("done_rdata", d_cur.is_d ? d_rdata : i_rdata, d_cur.rdata);
            check("done_timing", 32'(fell), 32'h1);
         end
      end
      m_req_prev = m_req;
   end

   // grant census for the strict-priority instance
   logic b_prev = 1'b0;
   int   b_i_grants = 0, b_d_grants = 0, b_i_dones = 0;
   always @(negedge clk) begin
      if (b_m_req && !b_prev) begin
         if (b_m_addr == 32'h0000_0100) b_i_grants++;
         else b_d_grants++;
      end
      if (b_i_done) b_i_dones++;
      b_prev = b_m_req;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // wait for n completions; drop_each releases each requester on its own DONE
   task automatic drive_until(input int n, input int budget, input logic drop_each);
      int seen = 0;
      for (int c = 0; c < budget && seen < n; c++) begin
         @(negedge clk);
         if (i_done || d_done) seen++;
         if (drop_each && i_done) i_req = 1'b0;
         if (drop_each && d_done) d_req = 1'b0;
         if (seen == n) begin
            i_req = 1'b0;
            d_req = 1'b0;
         end
      end
      check("done_count", seen, n);
   endtask

   task automatic pulse_reset;
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      int b_i0, b_d0, b_id0;
      rst = 1'b0;
      i_req = 0; d_req = 0; d_we = 0;
      i_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
      ack_en = 1; ack_force = 0; ack_delay = 0; mem_rdata = 0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctl", 32'({m_req, m_we, m_wstrb, i_done, i_err, d_done, d_err}), 32'h0);
      check("rst_addr", m_addr, 32'h0);
      check("rst_wdata", m_wdata, 32'h0);
      check("rst_i_rdata", i_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
      #1 rst = 1'b0;

      // single fetch, ack in the first request cycle
      tick;
      mem_rdata = 32'hDEAD_BEEF; ack_delay = 0;
      push_grant(0, 0, 32'h0000_1000, 32'h0, 4'h0, 1);
      push_done(0, 0, 32'hDEAD_BEEF);
      i_addr = 32'h0000_1000; i_req = 1;
      @(negedge clk);
      check("lat_before", 32'(m_req), 32'h0);
      @(posedge clk); #1;
      check("lat_after", 32'(m_req), 32'h1);
      drive_until(1, 20, 1);

      // simultaneous I and D (SW): D first, then I
      tick;
      mem_rdata = 32'hA5A5_0001; ack_delay = 1;
      push_grant(1, 1, 32'h0000_0040, 32'h1234_5678, 4'hF, 2);
      push_grant(0, 0, 32'h0000_0080, 32'h0, 4'h0, 2);
      push_done(1, 0, 32'hA5A5_0001);
      push_done(0, 0, 32'hA5A5_0001);
      i_addr = 32'h0000_0080; d_addr = 32'h0000_0040;
      d_we = 1; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
      i_req = 1; d_req = 1;
      drive_until(2, 40, 1);

      // continuous D and I: streak limit in dut_a, strict priority in dut_b
      pulse_reset;
      check("b_rst_mreq", 32'(b_m_req), 32'h0);
      mem_rdata = 32'h0000_0033; ack_delay = 0;
      i_addr = 32'h0000_0100; d_addr = 32'h0000_2000;
      d_we = 0; d_wdata = 32'h0000_FFFF; d_wstrb = 4'hF;
      for (int k = 0; k < 10; k++) begin
         if (k == 4 || k == 9) begin
            push_grant(0, 0, 32'h0000_0100, 32'h0, 4'h0, 1);
            push_done(0, 0, 32'h0000_0033);
         end else begin
            push_grant(1, 0, 32'h0000_2000, 32'h0, 4'h0, 1);
            push_done(1, 0, 32'h0000_0033);
         end
      end
      b_i0 = b_i_grants; b_d0 = b_d_grants; b_id0 = b_i_dones;
      i_req = 1; d_req = 1;
      drive_until(10, 100, 0);
      check("strict_i_grants", b_i_grants - b_i0, 0);
      check("strict_d_grants", b_d_grants - b_d0, 10);
      check("strict_i_dones", b_i_dones - b_id0, 0);

      // no ack at all: timeout after exactly 8 request cycles
      tick;
      ack_en = 0; mem_rdata = 32'h7777_7777;
      push_grant(1, 0, 32'h0000_3000, 32'h0, 4'h0, 8);
      push_done(1, 1, 32'h0);
      d_addr = 32'h0000_3000; d_we = 0; d_wstrb = 4'h0;
      d_req = 1;
      drive_until(1, 40, 1);

      // ack in the last timeout cycle wins over the timeout (SH store)
      tick;
      ack_en = 1; ack_delay = 7; mem_rdata = 32'h5555_AAAA;
      push_grant(1, 1, 32'h0000_3004, 32'hBEEF_0000, 4'hC, 8);
      push_done(1, 0, 32'h5555_AAAA);
      d_addr = 32'h0000_3004; d_we = 1; d_wdata = 32'hBEEF_0000; d_wstrb = 4'hC;
      d_req = 1;
      drive_until(1, 40, 1);

      // reset in BUSY, stray ack afterwards
      tick;
      ack_en = 0;
      push_grant(0, 0, 32'h0000_0300, 32'h0, 4'h0, 0);
      i_addr = 32'h0000_0300; i_req = 1;
      for (int c = 0; c < 10 && !m_req; c++) @(posedge clk);
      check("t6_granted", 32'(m_req), 32'h1);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1; i_req = 0;
      #1 check("t6_async_drop", 32'(m_req), 32'h0);
      check("t6_no_done", 32'({i_done, i_err}), 32'h0);
      @(posedge clk); #2 rst = 1'b0;
      ack_force = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("t6_stay_idle", 32'(m_req), 32'h0);
      end
      ack_force = 0;

      // arbiter still usable after the abandoned access
      tick;
      ack_en = 1; ack_delay = 0; mem_rdata = 32'h00C0_FFEE;
      push_grant(1, 0, 32'h0000_0044, 32'h0, 4'h0, 1);
      push_done(1, 0, 32'h00C0_FFEE);
      d_addr = 32'h0000_0044; d_we = 0; d_wstrb = 4'h3;
      d_req = 1;
      drive_until(1, 20, 1);

      repeat (3) tick;
      check("grant_queue_empty", exp_grant.size(), 0);
      check("done_queue_empty", exp_done.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
